flt_vram_slave: RTL and testbench

- AXI-style burst responder that models VRAM for the filter path: the read-address/read-data and write-address/write-data/response subset driven by the filter VRAM controller.
- Backed by a single-port, byte-enable on-chip RAM. Serves one burst at a time and arbitrates read and write bursts round-robin.
- Used as the VRAM endpoint in filter subsystem simulation and in small on-chip frame buffer builds.

---
 rtl/flt_vram_slave_pkg.sv | 30 +++
 rtl/flt_vram_spram.sv | 37 +++
 rtl/flt_vram_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_flt_vram_slave.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flt_vram_slave_pkg.sv
// Shared types and helpers for the filter-path VRAM burst responder.
//   state_t    : burst engine states
//   BEAT_BYTES : bytes carried by one data beat
//   word_index : unwrapped RAM word index of a given beat of a burst.
//                Callers truncate to the RAM address width, which makes
//                bursts wrap around the RAM.
package flt_vram_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RADDR,
      RBURST,
      WADDR,
      WBURST,
      WRESP
   } state_t;

   localparam int BEAT_BYTES = 4;

   // The byte lane bits of addr are dropped by the shift. The result is
   // not wrapped, so callers can use it for range checks.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [8:0]  beat);
      logic [31:0] offset;
      offset = addr - base;
      return (offset >> $clog2(BEAT_BYTES)) + {23'd0, beat};
   endfunction

endpackage

// File: rtl/flt_vram_spram.sv
// Single-port RAM: 2**ADDR_W words of 32 bits, one byte-enable bit per
// byte lane, and registered read data with one cycle of latency.
//   clk   : clock
//   en    : port enable. we == 0 means a read, any we bit set means a write.
//   we    : byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read
module flt_vram_spram #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   // NOTE: the storage array has no reset. A RAM macro cannot clear
   // itself, and the contents must survive RSTS.
   logic [31:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         if (we == 4'b0000) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/flt_vram_slave.sv
// AXI-style burst responder that models VRAM for the filter path. It
// serves one INCR burst at a time from a single-port byte-enable RAM.
// When read and write bursts request together, it grants them in
// round-robin order.
//   CLK, RSTS                       : clock, synchronous active-high reset
//   ARADDR/ARLEN/ARVALID/ARREADY    : read burst request
//   RDATA/RLAST/RVALID/RREADY       : read beats, from a 2-entry buffer
//   AWADDR/AWLEN/AWVALID/AWREADY    : write burst request
//   WDATA/WSTRB/WLAST/WVALID/WREADY : write beats
//   BVALID/BREADY                   : write response
//   ERR_WLAST                       : sticky, WLAST disagreed with the beat count
//   ERR_RANGE                       : sticky, a burst left the mapped window
module flt_vram_slave
   import flt_vram_slave_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RSTS,
   input  logic [31:0] ARADDR,
   input  logic [7:0]  ARLEN,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [31:0] AWADDR,
   input  logic [7:0]  AWLEN,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic        BVALID,
   input  logic        BREADY,
   output logic        ERR_WLAST,
   output logic        ERR_RANGE
);

   state_t            state, state_nxt;
   logic              rr_write_first;

   // Read side: captured request, issue counter, and the RAM read in flight.
   logic [31:0]       r_addr;
   logic [7:0]        r_len;
   logic [8:0]        r_issue;
   logic              inflight, inflight_last;

   // Read output buffer (2 entries).
   logic [31:0]       buf_data [2];
   logic              buf_last [2];
   logic              buf_rd, buf_wr;
   logic [1:0]        buf_occ, occ_after;

   // Write side.
   logic [31:0]       w_addr;
   logic [7:0]        w_len, w_beat;

   logic              pop, issue, w_hs, beats_left;
   logic [31:0]       chk_addr, chk_last_word;
   logic [7:0]        chk_len;
   logic              range_bad;

   logic [ADDR_W-1:0] rd_idx, wr_idx, ram_addr;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [31:0]       ram_rdata;

   assign RVALID    = (buf_occ != 2'd0);
   assign RDATA     = buf_data[buf_rd];
   assign RLAST     = buf_last[buf_rd];
   assign pop       = RVALID && RREADY;

   // A slot freed by this cycle's pop counts as free. Without this, a
   // stream with RREADY held high would run at half rate.
   assign occ_after  = buf_occ - {1'b0, pop};
   assign beats_left = (r_issue <= {1'b0, r_len});
   assign issue      = (state == RBURST) && beats_left &&
                       ((occ_after + {1'b0, inflight}) < 2'd2);
   assign w_hs       = (state == WBURST) && WVALID;

   assign rd_idx   = ADDR_W'(word_index(r_addr, BASE_ADDR, r_issue));
   assign wr_idx   = ADDR_W'(word_index(w_addr, BASE_ADDR, {1'b0, w_beat}));
   assign ram_en   = issue || w_hs;
   assign ram_we   = w_hs ? WSTRB : 4'b0000;
   assign ram_addr = w_hs ? wr_idx : rd_idx;

   // The range check runs in the address cycle. Beat indices rise
   // monotonically, so checking the last unwrapped word covers the whole
   // burst. An address below BASE_ADDR wraps to a huge offset and also fails.
   assign chk_addr      = (state == WADDR) ? AWADDR : ARADDR;
   assign chk_len       = (state == WADDR) ? AWLEN  : ARLEN;
   assign chk_last_word = word_index(chk_addr, BASE_ADDR, {1'b0, chk_len});
   assign range_bad     = (chk_last_word >> ADDR_W) != 32'd0;

   flt_vram_spram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (CLK),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (WDATA),
      .rdata (ram_rdata)
   );

   // NOTE: every output of this block gets a default before the case.
   // A path that assigns nothing would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      ARREADY   = 1'b0;
      AWREADY   = 1'b0;
      WREADY    = 1'b0;
      BVALID    = 1'b0;
      unique case (state)
         IDLE: begin
            if (ARVALID && AWVALID) begin
               state_nxt = rr_write_first ? WADDR : RADDR;
            end else if (ARVALID) begin
               state_nxt = RADDR;
            end else if (AWVALID) begin
               state_nxt = WADDR;
            end
         end
         RADDR: begin
            ARREADY   = 1'b1;
            state_nxt = RBURST;
         end
         RBURST: begin
            if (pop && RLAST) begin
               state_nxt = IDLE;
            end
         end
         WADDR: begin
            AWREADY   = 1'b1;
            state_nxt = WBURST;
         end
         WBURST: begin
            WREADY = 1'b1;
            if (WVALID && (w_beat == w_len)) begin
               state_nxt = WRESP;
            end
         end
         WRESP: begin
            BVALID = 1'b1;
            if (BREADY) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of every other register.
   always_ff @(posedge CLK) begin
      if (RSTS) begin
         state          <= IDLE;
         rr_write_first <= 1'b0;
         r_addr         <= '0;
         r_len          <= '0;
         r_issue        <= '0;
         inflight       <= 1'b0;
         inflight_last  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
         end
         buf_rd         <= 1'b0;
         buf_wr         <= 1'b0;
         buf_occ        <= '0;
         w_addr         <= '0;
         w_len          <= '0;
         w_beat         <= '0;
         ERR_WLAST      <= 1'b0;
         ERR_RANGE      <= 1'b0;
      end else begin
         state <= state_nxt;

         // The priority flag flips only when both sides compete. An
         // uncontested grant leaves the fairness order unchanged.
         if ((state == IDLE) && ARVALID && AWVALID) begin
            rr_write_first <= !rr_write_first;
         end

         if (state == RADDR) begin
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_issue <= '0;
         end else if (issue) begin
            r_issue <= r_issue + 9'd1;
         end

         inflight      <= issue;
         inflight_last <= (r_issue == {1'b0, r_len});

         if (inflight) begin
            buf_data[buf_wr] <= ram_rdata;
            buf_last[buf_wr] <= inflight_last;
            buf_wr           <= !buf_wr;
         end
         if (pop) begin
            buf_rd <= !buf_rd;
         end
         buf_occ <= occ_after + {1'b0, inflight};

         if (state == WADDR) begin
            w_addr <= AWADDR;
            w_len  <= AWLEN;
            w_beat <= '0;
         end else if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            if ((w_beat == w_len) != WLAST) begin
               ERR_WLAST <= 1'b1;
            end
         end

         if (((state == RADDR) || (state == WADDR)) && range_bad) begin
            ERR_RANGE <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flt_vram_slave.sv
// Self-checking bench for flt_vram_slave. A small word-array model of the
// mapped window holds the expected contents and error flags.
module tb_flt_vram_slave;

   localparam int          AW    = 6;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] BASE  = 32'h0000_0100;

   logic        CLK = 1'b0;
   logic        RSTS;
   logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
   logic [7:0]  ARLEN, AWLEN;
   logic [3:0]  WSTRB;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ERR_WLAST, ERR_RANGE;

   always #5 CLK = ~CLK;

   flt_vram_slave #(
      .ADDR_W    (AW),
      .BASE_ADDR (BASE)
   ) dut (
      .CLK       (CLK),
      .RSTS      (RSTS),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RDATA     (RDATA),
      .RLAST     (RLAST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .AWADDR    (AWADDR),
      .AWLEN     (AWLEN),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .WLAST     (WLAST),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .ERR_WLAST (ERR_WLAST),
      .ERR_RANGE (ERR_RANGE)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem_m [DEPTH];
   logic        exp_err_range, exp_err_wlast;
   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   int          r_first, r_span;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Model word index: byte offset from BASE in words, plus the beat,
   // modulo the RAM depth.
   function automatic int widx(input logic [31:0] addr, input int beat);
      logic [31:0] off;
      off = addr - BASE;
      return int'(((off / 4) + beat) % DEPTH);
   endfunction

   function automatic bit burst_out(input logic [31:0] addr, input int len);
      longint first;
      first = longint'((addr - BASE) / 4);
      return (addr < BASE) || (first + len >= DEPTH);
   endfunction

   task automatic check_err(input string tag);
      check({tag, "_err_range"}, ERR_RANGE, exp_err_range);
      check({tag, "_err_wlast"}, ERR_WLAST, exp_err_wlast);
   endtask

   task automatic do_reset();
      RSTS = 1'b1;
      step();
      step();
      RSTS = 1'b0;
      exp_err_range = 1'b0;
      exp_err_wlast = 1'b0;
   endtask

   task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      ARADDR  = addr;
      ARLEN   = len;
      ARVALID = 1'b1;
      while (ARREADY !== 1'b1 && n < 50) begin step(); n++; end
      check("ar_grant", ARREADY, 1);
      step();
      ARVALID = 1'b0;
      if (burst_out(addr, int'(len))) exp_err_range = 1'b1;
   endtask

   task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      AWADDR  = addr;
      AWLEN   = len;
      AWVALID = 1'b1;
      while (AWREADY !== 1'b1 && n < 50) begin step(); n++; end
      check("aw_grant", AWREADY, 1);
      step();
      AWVALID = 1'b0;
      if (burst_out(addr, int'(len))) exp_err_range = 1'b1;
   endtask

   // Sends beats 0..len from wd/ws and raises WLAST on beat wlast_beat.
   // Also updates the model and completes the B response.
   task automatic w_data(input logic [31:0] addr, input int len, input int wlast_beat);
      int n;
      for (int b = 0; b <= len; b++) begin
         WDATA  = wd[b];
         WSTRB  = ws[b];
         WLAST  = (b == wlast_beat);
         WVALID = 1'b1;
         n = 0;
         while (WREADY !== 1'b1 && n < 50) begin step(); n++; end
         check("w_ready", WREADY, 1);
         step();
         for (int k = 0; k < 4; k++) begin
            if (ws[b][k]) mem_m[widx(addr, b)][8*k +: 8] = wd[b][8*k +: 8];
         end
         if ((b == len) != (b == wlast_beat)) exp_err_wlast = 1'b1;
         check("w_ready_after_beat", WREADY, (b < len));
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      n = 0;
      while (BVALID !== 1'b1 && n < 50) begin step(); n++; end
      check("bvalid", BVALID, 1);
      step();
      check("bvalid_hold", BVALID, 1);
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;
      check("bvalid_clear", BVALID, 0);
   endtask

   // Collects read beats and checks them against the model. Set rnd for
   // random RREADY. abort_at >= 0 stops after that many beats.
   task automatic r_data(input logic [31:0] addr, input int len, input bit rnd, input int abort_at);
      int          beat = 0;
      int          n = 0;
      bit          stalled = 1'b0;
      logic [31:0] held_d = '0;
      logic        held_l = 1'b0;
      r_first = -1;
      while (beat <= len && n < 4000) begin
         if (stalled) begin
            check("hold_rvalid", RVALID, 1);
            check("hold_rdata", RDATA, held_d);
            check("hold_rlast", RLAST, held_l);
         end
         RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (RVALID === 1'b1 && r_first < 0) r_first = n;
         if (RVALID === 1'b1 && RREADY) begin
            check("rdata", RDATA, mem_m[widx(addr, beat)]);
            check("rlast", RLAST, (beat == len));
            beat++;
         end
         stalled = (RVALID === 1'b1) && !RREADY;
         held_d  = RDATA;
         held_l  = RLAST;
         step();
         n++;
         if (abort_at >= 0 && beat == abort_at) break;
      end
      RREADY = 1'b0;
      r_span = n - r_first;
      check("r_beats", beat, (abort_at >= 0) ? abort_at : len + 1);
      if (abort_at < 0) check("rvalid_end", RVALID, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RSTS = 1'b1;
      ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
      AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      exp_err_range = 1'b0;
      exp_err_wlast = 1'b0;
      repeat (3) step();
      RSTS = 1'b0;

      // Reset state
      check("rst_arready", ARREADY, 0);
      check("rst_awready", AWREADY, 0);
      check("rst_rvalid",  RVALID,  0);
      check("rst_rdata",   RDATA,   0);
      check("rst_rlast",   RLAST,   0);
      check("rst_wready",  WREADY,  0);
      check("rst_bvalid",  BVALID,  0);
      check_err("rst");
      step();

      // Four-beat write, then read back with RREADY held high
      for (int b = 0; b < 4; b++) begin
         wd[b] = 32'h1111_1111 * (b + 1);
         ws[b] = 4'hF;
      end
      aw_phase(BASE + 32'h40, 8'd3);
      w_data(BASE + 32'h40, 3, 3);
      check_err("wr4");
      ar_phase(BASE + 32'h40, 8'd3);
      r_data(BASE + 32'h40, 3, 1'b0, -1);
      check("rd4_first_latency", r_first, 2);
      check("rd4_consecutive", r_span, 4);
      check_err("rd4");

      // Byte strobes
      wd[0] = 32'h0000_0000; ws[0] = 4'hF;
      aw_phase(BASE, 8'd0);
      w_data(BASE, 0, 0);
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
      aw_phase(BASE, 8'd0);
      w_data(BASE, 0, 0);
      ar_phase(BASE, 8'd0);
      r_data(BASE, 0, 1'b0, -1);

      // Fill the window with random data, then run a 256-beat read with
      // random backpressure. The read wraps the window and flags range.
      for (int b = 0; b < DEPTH; b++) begin
         wd[b] = $urandom;
         ws[b] = 4'hF;
      end
      aw_phase(BASE, 8'(DEPTH - 1));
      w_data(BASE, DEPTH - 1, DEPTH - 1);
      check_err("fill");
      ar_phase(BASE, 8'd255);
      r_data(BASE, 255, 1'b1, -1);
      check_err("rd256");

      // Arbitration from reset: read wins first, then the waiting write.
      do_reset();
      check_err("arb_rst");
      wd[0] = $urandom; ws[0] = 4'hF;
      ARADDR = BASE + 32'h80; ARLEN = 8'd0; ARVALID = 1'b1;
      AWADDR = BASE + 32'h84; AWLEN = 8'd0; AWVALID = 1'b1;
      for (int n = 0; n < 50 && ARREADY !== 1'b1 && AWREADY !== 1'b1; n++) step();
      check("arb1_read_first", {AWREADY, ARREADY}, 2'b01);
      ar_phase(BASE + 32'h80, 8'd0);
      r_data(BASE + 32'h80, 0, 1'b0, -1);
      aw_phase(BASE + 32'h84, 8'd0);
      w_data(BASE + 32'h84, 0, 0);
      // Second contest: write wins.
      wd[0] = $urandom; ws[0] = 4'hF;
      ARADDR = BASE + 32'h84; ARLEN = 8'd0; ARVALID = 1'b1;
      AWADDR = BASE + 32'h88; AWLEN = 8'd0; AWVALID = 1'b1;
      for (int n = 0; n < 50 && ARREADY !== 1'b1 && AWREADY !== 1'b1; n++) step();
      check("arb2_write_first", {AWREADY, ARREADY}, 2'b10);
      aw_phase(BASE + 32'h88, 8'd0);
      w_data(BASE + 32'h88, 0, 0);
      ar_phase(BASE + 32'h84, 8'd0);
      r_data(BASE + 32'h84, 0, 1'b0, -1);

      // Reset pulse after 5 beats of a 16-beat read
      ar_phase(BASE, 8'd15);
      r_data(BASE, 15, 1'b0, 5);
      RSTS = 1'b1;
      step();
      RSTS = 1'b0;
      exp_err_range = 1'b0;
      exp_err_wlast = 1'b0;
      check("abort_rvalid", RVALID, 0);
      check("abort_arready", ARREADY, 0);
      check("abort_bvalid", BVALID, 0);
      check_err("abort");
      ar_phase(BASE, 8'd15);
      r_data(BASE, 15, 1'b0, -1);
      check("reread_first_latency", r_first, 2);

      // Wrap: the second beat from the top word lands in word 0
      wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
      aw_phase(BASE + 32'h0FC, 8'd1);
      w_data(BASE + 32'h0FC, 1, 1);
      check_err("wrap");
      ar_phase(BASE, 8'd0);
      r_data(BASE, 0, 1'b0, -1);
      ar_phase(BASE + 32'h0FC, 8'd1);
      r_data(BASE + 32'h0FC, 1, 1'b0, -1);

      // Early WLAST: the burst still takes all three beats
      for (int b = 0; b < 3; b++) begin
         wd[b] = $urandom;
         ws[b] = 4'(b + 3);
      end
      aw_phase(BASE + 32'h10, 8'd2);
      w_data(BASE + 32'h10, 2, 1);
      check_err("wlast");
      ar_phase(BASE + 32'h10, 8'd2);
      r_data(BASE + 32'h10, 2, 1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
